// File: rtl/melody_pkg.sv
// Shared types and constants for the melody sequencer: note codes, tone divisors,
// ROM entry layout, the default melody and the sequencer state encoding.
package melody_pkg;

   typedef enum logic [3:0] {
      REST = 4'd0,
      DO1, RE1, MI1, FA1, SO1, LA1, SI1,
      DO2, RE2, MI2, FA2, SO2, LA2, SI2,
      DO3
   } note_e;

   // Full-period divisors for a 50 MHz clock (clock / pitch).
   localparam int unsigned DIV_DO1 = 382234;
   localparam int unsigned DIV_RE1 = 340136;
   localparam int unsigned DIV_MI1 = 303380;
   localparam int unsigned DIV_FA1 = 286352;
   localparam int unsigned DIV_SO1 = 255102;
   localparam int unsigned DIV_LA1 = 227273;
   localparam int unsigned DIV_SI1 = 202478;
   localparam int unsigned DIV_DO2 = 191110;
   localparam int unsigned DIV_RE2 = 170068;
   localparam int unsigned DIV_MI2 = 151690;
   localparam int unsigned DIV_FA2 = 143176;
   localparam int unsigned DIV_SO2 = 127551;
   localparam int unsigned DIV_LA2 = 113636;
   localparam int unsigned DIV_SI2 = 101239;
   localparam int unsigned DIV_DO3 = 95556;

   typedef struct packed {
      note_e      note;
      logic [3:0] dur;
   } rom_entry_t;

   localparam int MELODY_LEN = 16;

   // Bring-up tune; everything after the first end marker is also an end marker.
   localparam rom_entry_t MELODY [MELODY_LEN] = '{
      '{RE1,  4'd2}, '{REST, 4'd1}, '{MI1,  4'd1}, '{REST, 4'd0},
      '{REST, 4'd0}, '{REST, 4'd0}, '{REST, 4'd0}, '{REST, 4'd0},
      '{REST, 4'd0}, '{REST, 4'd0}, '{REST, 4'd0}, '{REST, 4'd0},
      '{REST, 4'd0}, '{REST, 4'd0}, '{REST, 4'd0}, '{REST, 4'd0}
   };

   typedef enum logic [2:0] {
      IDLE, LOAD, PLAY, GAP, DONE
   } state_e;

   function automatic logic [31:0] note_divisor(input note_e n);
      case (n)
         DO1:     return DIV_DO1;
         RE1:     return DIV_RE1;
         MI1:     return DIV_MI1;
         FA1:     return DIV_FA1;
         SO1:     return DIV_SO1;
         LA1:     return DIV_LA1;
         SI1:     return DIV_SI1;
         DO2:     return DIV_DO2;
         RE2:     return DIV_RE2;
         MI2:     return DIV_MI2;
         FA2:     return DIV_FA2;
         SO2:     return DIV_SO2;
         LA2:     return DIV_LA2;
         SI2:     return DIV_SI2;
         DO3:     return DIV_DO3;
         default: return 32'd0;
      endcase
   endfunction

endpackage

// File: rtl/melody_sequencer_tone.sv
// Programmable square-wave divider: counts 0..divisor-1 and drives the output
// high for the first divisor/2 counts; clear restarts the period, mute gates the pin.
module tone_gen
   import melody_pkg::*;
#(
   parameter int DIV_W = 28
) (
   input  logic             clock_in,
   input  logic             rst_n,
   input  logic [DIV_W-1:0] divisor,
   input  logic             clear,
   input  logic             mute,
   output logic             tone_out
);

   logic [DIV_W-1:0] count;
   logic             wrap;
   logic             high;

   always_comb begin
      wrap = (divisor == '0) || (count >= divisor - DIV_W'(1));
      high = (divisor > DIV_W'(1)) && (count < (divisor >> 1));
   end

   always_ff @(posedge clock_in or negedge rst_n) begin
      if (!rst_n) begin
         count    <= '0;
         tone_out <= 1'b0;
      end else begin
         tone_out <= high && !mute;
         if (clear || wrap) count <= '0;
         else               count <= count + DIV_W'(1);
      end
   end

endmodule

// File: rtl/melody_sequencer.sv
// Steps through the melody ROM, programming one shared tone divider per note,
// holding each note for dur tempo units followed by a muted gap.
module melody_sequencer
   import melody_pkg::*;
#(
   parameter int TEMPO_TICKS = 6_250_000,
   parameter int GAP_TICKS   = 500_000,
   parameter int NUM_NOTES   = 16,
   parameter int DIV_W       = 28
) (
   input  logic                         clock_in,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         stop,
   input  logic                         loop_en,
   output logic                         tone_out,
   output logic [DIV_W-1:0]             divisor,
   output logic [$clog2(NUM_NOTES)-1:0] note_idx,
   output logic                         busy,
   output logic                         done
);

   localparam int IDX_W = $clog2(NUM_NOTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NOTES - 1);

   state_e           state, state_next;
   logic [IDX_W-1:0] idx_next;
   logic [31:0]      dur_cnt;
   logic [31:0]      play_ticks;
   rom_entry_t       entry;
   logic             at_end;
   logic             tone_clear;
   logic             tone_mute;

   always_comb begin
      entry      = (int'(note_idx) < MELODY_LEN) ? MELODY[note_idx] : '0;
      play_ticks = 32'(entry.dur) * 32'(TEMPO_TICKS);
   end

   always_comb begin
      state_next = state;
      idx_next   = note_idx;
      at_end     = 1'b0;
      if (stop) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: if (start) begin
               state_next = LOAD;
               idx_next   = '0;
            end
            LOAD: begin
               if (entry.dur == 4'd0) at_end = 1'b1;
               else                   state_next = PLAY;
            end
            PLAY: if (dur_cnt == '0) state_next = GAP;
            GAP: if (dur_cnt == '0) begin
               if (note_idx == LAST_IDX) begin
                  at_end = 1'b1;
               end else begin
                  idx_next   = note_idx + IDX_W'(1);
                  state_next = LOAD;
               end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
         if (at_end) begin
            if (loop_en) begin
               state_next = LOAD;
               idx_next   = '0;
            end else begin
               state_next = DONE;
            end
         end
      end
   end

   always_ff @(posedge clock_in or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clock_in or negedge rst_n) begin
      if (!rst_n) begin
         note_idx <= '0;
         divisor  <= '0;
         dur_cnt  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         note_idx <= idx_next;
         busy     <= (state_next != IDLE);
         done     <= (state_next == DONE);
         if (state_next == IDLE || state_next == DONE)
            divisor <= '0;
         else if (state == LOAD && state_next == PLAY)
            divisor <= DIV_W'(note_divisor(entry.note));
         if (state_next == IDLE)
            dur_cnt <= '0;
         else if (state == LOAD && state_next == PLAY)
            dur_cnt <= play_ticks - 32'd1;
         else if (state == PLAY && state_next == GAP)
            dur_cnt <= 32'(GAP_TICKS) - 32'd1;
         else if (dur_cnt != '0)
            dur_cnt <= dur_cnt - 32'd1;
      end
   end

   // The tone only sounds on PLAY-to-PLAY cycles, so the first PLAY cycle
   // and every gap, stop and end cycle are silent.
   always_comb begin
      tone_clear = (state == LOAD);
      tone_mute  = !(state == PLAY && state_next == PLAY);
   end

   tone_gen #(.DIV_W(DIV_W)) u_tone (
      .clock_in (clock_in),
      .rst_n    (rst_n),
      .divisor  (divisor),
      .clear    (tone_clear),
      .mute     (tone_mute),
      .tone_out (tone_out)
   );

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: tone divider vector table, a per-cycle reference
// trace built from the melody rules, directed stop/reset sequences and random runs.
module tb_melody_sequencer;

   localparam int T     = 10;
   localparam int G     = 2;
   localparam int DIV_W = 28;
   localparam int IDX_W = 4;

   logic             clock_in = 1'b0;
   logic             rst_n    = 1'b0;
   logic             start    = 1'b0;
   logic             stop     = 1'b0;
   logic             loop_en  = 1'b0;
   logic             tone_out;
   logic [DIV_W-1:0] divisor;
   logic [IDX_W-1:0] note_idx;
   logic             busy;
   logic             done;

   logic [DIV_W-1:0] tg_div   = '0;
   logic             tg_clear = 1'b0;
   logic             tg_mute  = 1'b0;
   logic             tg_tone;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic [DIV_W-1:0] div;
      logic             tone;
      logic             busy;
      logic             done;
      logic [IDX_W-1:0] idx;
      bit               chk_idx;
   } exp_t;

   typedef struct {
      logic [DIV_W-1:0] div;
      logic             clr;
      logic             mute;
      logic             tone;
   } tg_vec_t;

   exp_t    q[$];
   tg_vec_t tv[$];
   int      rom_div[4];
   int      rom_dur[4];

   melody_sequencer #(
      .TEMPO_TICKS (T),
      .GAP_TICKS   (G),
      .NUM_NOTES   (16),
      .DIV_W       (DIV_W)
   ) dut (
      .clock_in (clock_in),
      .rst_n    (rst_n),
      .start    (start),
      .stop     (stop),
      .loop_en  (loop_en),
      .tone_out (tone_out),
      .divisor  (divisor),
      .note_idx (note_idx),
      .busy     (busy),
      .done     (done)
   );

   tone_gen #(.DIV_W(DIV_W)) tg (
      .clock_in (clock_in),
      .rst_n    (rst_n),
      .divisor  (tg_div),
      .clear    (tg_clear),
      .mute     (tg_mute),
      .tone_out (tg_tone)
   );

   always #5 clock_in = ~clock_in;

   function automatic exp_t mk(input int d, input int t, input int b, input int dn,
                               input int i, input int ci);
      exp_t e;
      e.div     = DIV_W'(d);
      e.tone    = (t != 0);
      e.busy    = (b != 0);
      e.done    = (dn != 0);
      e.idx     = IDX_W'(i);
      e.chk_idx = (ci != 0);
      return e;
   endfunction

   function automatic tg_vec_t mkt(input int d, input int c, input int m, input int t);
      tg_vec_t v;
      v.div  = DIV_W'(d);
      v.clr  = (c != 0);
      v.mute = (m != 0);
      v.tone = (t != 0);
      return v;
   endfunction

   task automatic step();
      @(posedge clock_in);
      #1;
   endtask

   task automatic check(input string name, input int cyc, input exp_t e);
      vectors++;
      if (divisor !== e.div || tone_out !== e.tone || busy !== e.busy || done !== e.done ||
          (e.chk_idx && note_idx !== e.idx)) begin
         miscompares++;
         $display("FAIL %s cycle %0d: got div=%0d tone=%0b busy=%0b done=%0b idx=%0d, want div=%0d tone=%0b busy=%0b done=%0b idx=%0d",
                  name, cyc, divisor, tone_out, busy, done, note_idx,
                  e.div, e.tone, e.busy, e.done, e.idx);
      end
   endtask

   // Expected per-cycle trace from the cycle after start is taken.
   task automatic build(input bit lp, input int maxlen);
      int i;
      int prev;
      int d;
      bit t;
      i    = 0;
      prev = 0;
      q.delete();
      while (q.size() < maxlen) begin
         q.push_back(mk(prev, 0, 1, 0, i, 1));
         if (rom_dur[i] == 0) begin
            if (lp) begin
               i = 0;
               continue;
            end
            q.push_back(mk(0, 0, 1, 1, i, 0));
            q.push_back(mk(0, 0, 0, 0, i, 0));
            break;
         end
         d = rom_div[i];
         for (int k = 0; k < rom_dur[i] * T; k++) begin
            t = 1'b0;
            if (k > 0 && d >= 2) t = (((k - 1) % d) < d / 2);
            q.push_back(mk(d, int'(t), 1, 0, i, 1));
         end
         for (int g = 0; g < G; g++) q.push_back(mk(d, 0, 1, 0, i, 1));
         prev = d;
         i++;
      end
   endtask

   task automatic run_check(input string name, input bit lp, input int stop_at,
                            input int maxlen, input bit rand_start);
      build(lp, maxlen);
      loop_en = lp;
      start   = 1'b1;
      step();
      start   = 1'b0;
      for (int c = 0; c < q.size(); c++) begin
         check(name, c + 1, q[c]);
         if (c == q.size() - 1) break;
         if (c + 1 == stop_at) begin
            stop = 1'b1;
            while (q.size() > c + 1) void'(q.pop_back());
            q.push_back(mk(0, 0, 0, 0, 0, 0));
         end
         if (rand_start && q[c].busy && $urandom_range(0, 5) == 0) start = 1'b1;
         step();
         start = 1'b0;
         stop  = 1'b0;
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      check({name, "_final_stop"}, 0, mk(0, 0, 0, 0, 0, 0));
   endtask

   initial begin
      rom_div = '{340136, 0, 303380, 0};
      rom_dur = '{2, 1, 1, 0};

      tv.push_back(mkt(6, 1, 1, 0));
      for (int i = 0; i < 12; i++) tv.push_back(mkt(6, 0, 0, ((i % 6) < 3) ? 1 : 0));
      tv.push_back(mkt(6, 0, 1, 0));
      tv.push_back(mkt(6, 1, 0, 1));
      tv.push_back(mkt(6, 0, 0, 1));
      tv.push_back(mkt(1, 1, 0, 0));
      tv.push_back(mkt(1, 0, 0, 0));
      tv.push_back(mkt(0, 0, 0, 0));
      tv.push_back(mkt(2, 1, 1, 0));
      tv.push_back(mkt(2, 0, 0, 1));
      tv.push_back(mkt(2, 0, 0, 0));
      tv.push_back(mkt(2, 0, 0, 1));
      tv.push_back(mkt(2, 0, 0, 0));
      tv.push_back(mkt(7, 1, 1, 0));
      tv.push_back(mkt(7, 0, 0, 1));
      tv.push_back(mkt(7, 0, 0, 1));
      tv.push_back(mkt(7, 0, 0, 1));
      tv.push_back(mkt(7, 0, 0, 0));
      tv.push_back(mkt(7, 0, 0, 0));
      tv.push_back(mkt(7, 0, 0, 0));
      tv.push_back(mkt(7, 0, 0, 0));
      tv.push_back(mkt(7, 0, 0, 1));

      // Reset state.
      repeat (3) @(posedge clock_in);
      #1;
      check("reset_hold", 0, mk(0, 0, 0, 0, 0, 1));
      rst_n = 1'b1;
      step();
      check("idle_after_reset", 0, mk(0, 0, 0, 0, 0, 1));

      // Divider table.
      for (int i = 0; i < tv.size(); i++) begin
         tg_div   = tv[i].div;
         tg_clear = tv[i].clr;
         tg_mute  = tv[i].mute;
         step();
         vectors++;
         if (tg_tone !== tv[i].tone) begin
            miscompares++;
            $display("FAIL tone_gen[%0d] div=%0d: got tone=%0b want %0b",
                     i, tv[i].div, tg_tone, tv[i].tone);
         end
      end
      tg_div   = '0;
      tg_clear = 1'b0;
      tg_mute  = 1'b0;

      run_check("play_once", 1'b0, 0, 200, 1'b0);
      run_check("play_loop", 1'b1, 0, 130, 1'b0);
      run_check("stop_mid_play", 1'b0, 10, 200, 1'b0);

      start = 1'b1;
      stop  = 1'b1;
      step();
      start = 1'b0;
      stop  = 1'b0;
      check("start_with_stop", 0, mk(0, 0, 0, 0, 0, 0));
      step();
      check("start_with_stop_hold", 0, mk(0, 0, 0, 0, 0, 0));

      run_check("start_while_busy", 1'b0, 0, 200, 1'b1);

      // Asynchronous reset in the first gap, then replay from entry 0.
      build(1'b0, 200);
      loop_en = 1'b0;
      start   = 1'b1;
      step();
      start   = 1'b0;
      for (int c = 0; c <= 21; c++) begin
         check("pre_gap_reset", c + 1, q[c]);
         if (c < 21) step();
      end
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_in_gap", 0, mk(0, 0, 0, 0, 0, 1));
      #3 rst_n = 1'b1;
      run_check("replay_after_reset", 1'b0, 0, 200, 1'b0);

      for (int r = 0; r < 10; r++) begin
         bit lp;
         int sa;
         lp = bit'($urandom_range(0, 1));
         sa = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 90));
         run_check($sformatf("random_%0d", r), lp, sa, 110, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Plays a fixed melody by sequencing note entries from a ROM into a programmable tone divider. Each note is held for a programmed number of tempo units, followed by a short muted gap. Sits between the game control logic (start/stop/loop) and the speaker pin, and replaces per-note fixed dividers with one shared, reconfigured divider.

## Interface
- `TEMPO_TICKS`, default 6_250_000: clock cycles per duration unit (125 ms at 50 MHz).
- `GAP_TICKS`, default 500_000: muted cycles between notes.
- `NUM_NOTES`, default 16: melody ROM depth.
- `DIV_W`, default 28: divisor and counter width.
- `clock_in` (in, 1): system clock, 50 MHz.
- `rst_n` (in, 1): reset, asynchronous, active-low.
- `start` (in, 1): one-cycle request to begin playback from entry 0.
- `stop` (in, 1): one-cycle abort request.
- `loop_en` (in, 1): at melody end, restart instead of finishing.
- `tone_out` (out, 1): square wave to the speaker.
- `divisor` (out, DIV_W): divisor currently applied; 0 means silent.
- `note_idx` (out, $clog2(NUM_NOTES)): ROM entry being played.
- `busy` (out, 1): high in every state except IDLE.
- `done` (out, 1): one-cycle pulse when a non-looping melody finishes.

## Operation
- ROM entry fields: `note` (4 b, code 0 = rest) and `dur` (4 b, in tempo units). `dur = 0` is the end marker.
- Note code → divisor lookup comes from the package; rest → 0.
- FSM states: IDLE, LOAD, PLAY, GAP, DONE.
- IDLE:
  - `start` → LOAD with `note_idx` = 0.
  - `start` while not IDLE is ignored.
- LOAD (1 cycle):
  - Registers `divisor` from the entry.
  - Loads the duration counter with `dur*TEMPO_TICKS - 1`.
  - If `dur = 0`, goes to end handling instead.
  - Otherwise → PLAY.
- PLAY:
  - Counts down to 0 → GAP.
  - GAP counter is loaded with `GAP_TICKS - 1`.
- GAP:
  - `tone_out` is forced to 0 while `divisor` stays unchanged.
  - At count 0: if `note_idx = NUM_NOTES-1`, go to end handling; else increment `note_idx` → LOAD.
- End handling:
  - `loop_en = 1` → LOAD with `note_idx` = 0.
  - `loop_en = 0` → DONE.
- DONE (1 cycle): `done` = 1, `divisor` = 0 → IDLE.
- `stop` in any state → IDLE next cycle, with `divisor` = 0 and `tone_out` = 0. If `stop` and `start` are asserted in the same cycle, `stop` wins.
- Tone divider rules:
  - Counter runs 0..`divisor`-1, then wraps to 0.
  - `tone_out` = 1 while counter < `divisor`/2 (integer division), else 0.
  - Counter clears to 0 on every LOAD.
  - `divisor` of 0 or 1 gives `tone_out` = 0.
- Arithmetic:
  - `dur*TEMPO_TICKS` is computed at 32 bits.
  - The tone counter is DIV_W bits and never exceeds `divisor`-1.

## Timing
- Reset values:
  - state IDLE; `tone_out` 0; `divisor` 0; `note_idx` 0; `busy` 0; `done` 0; all counters 0.
- Reset mid-play returns to these values immediately (asynchronous).
- All outputs are registered.
- `start` at cycle 0 → LOAD at cycle 1 → `divisor` valid and state PLAY at cycle 2.
- The first `tone_out` high appears at cycle 3.
- PLAY lasts exactly `dur*TEMPO_TICKS` cycles; GAP lasts exactly `GAP_TICKS` cycles; LOAD lasts 1 cycle.
- Note-to-note period is therefore `dur*TEMPO_TICKS + GAP_TICKS + 1` cycles.
- `busy` rises the cycle after `start` is accepted and falls the cycle after DONE or `stop`.

## Structure
- Package `melody_pkg` contains:
  - the note-code enum;
  - divisor constants (e.g. `RE1` = 340136, one per note);
  - the ROM entry struct;
  - the default melody array;
  - the state enum.
- Sub-module `tone_gen`: programmable divider with inputs `clock_in`, `rst_n`, `divisor`, `clear`, `mute` and output `tone_out`.
- The FSM and ROM stay in `melody_sequencer`.

## Test plan
All scenarios use `TEMPO_TICKS=10`, `GAP_TICKS=2`, and a ROM of {RE1, 2}, {rest, 1}, {MI1, 1}, end marker.
- Reset, then `start` at cycle 0:
  - `divisor` = 340136 at cycle 2, held for 20 cycles, then 2 gap cycles with `tone_out` 0.
  - `note_idx` = 1 at the next LOAD.
- Full run with `loop_en=0`:
  - Rest entry gives `divisor` 0 and `tone_out` 0 for 10 cycles.
  - `done` pulses once.
  - `busy` falls, and `divisor` = 0 at the end.
- Full run with `loop_en=1`: after the end marker, `note_idx` returns to 0, `divisor` is again 340136, and `done` never pulses.
- Direct `tone_gen` test with `divisor`=6: `tone_out` pattern 111000 repeating from counter 0.
- Stop handling:
  - `stop` in mid-PLAY gives IDLE next cycle with `tone_out` 0.
  - `start` together with `stop` stays in IDLE.
  - `start` while busy has no effect on `note_idx`.
- Async reset:
  - `rst_n` low during GAP: all outputs reach reset values without a clock edge.
  - After release, `start` replays from entry 0.
